// File: rtl/slv_guard_pkg.sv
// -----------------------------------------------------------------------------
// slv_guard_pkg
// Shared types and widths for the slave-guard recovery controller.
//   state_e  : recovery FSM state encoding (visible on state_o)
//   TIMER_W  : width of the shared phase down-counter
//   CNT_W    : width of the completed-recovery counter
//   sat_inc  : saturating increment for the recovery counter
// -----------------------------------------------------------------------------
package slv_guard_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned TIMER_W = 16;
  localparam int unsigned CNT_W   = 8;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_ISOLATE = 3'd1,
    ST_RESET   = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_RELEASE = 3'd4,
    ST_LOCKED  = 3'd5
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/slv_guard_recovery_ctrl.sv
// -----------------------------------------------------------------------------
// slv_guard_recovery_ctrl
// Recovers a hung AXI subordinate: isolate the path, wait for drain (bounded
// by a timeout), pulse the subordinate reset, let it settle, then release.
// Locks out after MaxRecoveries completed recoveries until software clears.
//
// Ports
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   guard_ena_i     : allows new recovery sequences to start
//   rst_req_i       : reset request level from the slave guard
//   isolated_i      : isolation stage reports path isolated and drained
//   sw_clear_i      : clears sticky flags; leaves LOCKED
//   isolate_o       : isolate request to the AXI isolation stage
//   slv_rst_o       : active-high subordinate reset
//   irq_o           : sticky recovery interrupt
//   iso_timeout_o   : sticky flag, isolation acknowledge never arrived
//   locked_o        : lockout active
//   busy_o          : controller not idle
//   state_o         : current FSM state
//   recov_cnt_o     : completed recoveries (saturating)
// -----------------------------------------------------------------------------
module slv_guard_recovery_ctrl
  import slv_guard_pkg::*;
#(
  parameter int unsigned RstCycles     = 16,
  parameter int unsigned SettleCycles  = 8,
  parameter int unsigned IsoTimeout    = 256,
  parameter int unsigned MaxRecoveries = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               guard_ena_i,
  input  logic               rst_req_i,
  input  logic               isolated_i,
  input  logic               sw_clear_i,
  output logic               isolate_o,
  output logic               slv_rst_o,
  output logic               irq_o,
  output logic               iso_timeout_o,
  output logic               locked_o,
  output logic               busy_o,
  output logic [STATE_W-1:0] state_o,
  output logic [CNT_W-1:0]   recov_cnt_o
);

  // Timer loads are "cycles - 1" so each phase lasts exactly the parameter.
  localparam logic [TIMER_W-1:0] ISO_LOAD    = TIMER_W'(IsoTimeout - 1);
  localparam logic [TIMER_W-1:0] RST_LOAD    = TIMER_W'(RstCycles - 1);
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SettleCycles - 1);
  localparam logic [CNT_W-1:0]   MAX_REC     = CNT_W'(MaxRecoveries);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               irq_q, irq_d;
  logic               iso_to_q, iso_to_d;
  logic               isolate_q, isolate_d;
  logic               slv_rst_q, slv_rst_d;
  logic               locked_q, locked_d;
  logic               busy_q, busy_d;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    timer_d  = timer_q;
    cnt_d    = cnt_q;
    irq_d    = irq_q;
    iso_to_d = iso_to_q;

    // Clear first; the set events in the case below overwrite it, so a
    // same-cycle set wins over the clear.
    if (sw_clear_i) begin
      irq_d    = 1'b0;
      iso_to_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rst_req_i && guard_ena_i) begin
          state_d = ST_ISOLATE;
          timer_d = ISO_LOAD;
          irq_d   = 1'b1;
        end
      end
      ST_ISOLATE: begin
        // Acknowledge is checked first so an ack on the last cycle is not
        // reported as a timeout.
        if (isolated_i) begin
          state_d = ST_RESET;
          timer_d = RST_LOAD;
        end else if (timer_q == '0) begin
          state_d  = ST_RESET;
          timer_d  = RST_LOAD;
          iso_to_d = 1'b1;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_RESET: begin
        if (timer_q == '0) begin
          state_d = ST_SETTLE;
          timer_d = SETTLE_LOAD;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_SETTLE: begin
        if (timer_q == '0) begin
          state_d = ST_RELEASE;
          cnt_d   = sat_inc(cnt_q);
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_RELEASE: begin
        // cnt_q already holds the count incremented on RELEASE entry.
        state_d = (cnt_q >= MAX_REC) ? ST_LOCKED : ST_IDLE;
      end
      ST_LOCKED: begin
        if (sw_clear_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as state_o.
    isolate_d = (state_d == ST_ISOLATE) || (state_d == ST_RESET) ||
                (state_d == ST_SETTLE)  || (state_d == ST_LOCKED);
    slv_rst_d = (state_d == ST_RESET);
    locked_d  = (state_d == ST_LOCKED);
    busy_d    = (state_d != ST_IDLE);
  end

  // NOTE: the asynchronous reset clears every flop, so slv_rst_o drops the
  // moment rst_i rises, even in the middle of a recovery.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
      iso_to_q  <= 1'b0;
      isolate_q <= 1'b0;
      slv_rst_q <= 1'b0;
      locked_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // values, independent of statement order.
      state_q   <= state_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
      iso_to_q  <= iso_to_d;
      isolate_q <= isolate_d;
      slv_rst_q <= slv_rst_d;
      locked_q  <= locked_d;
      busy_q    <= busy_d;
    end
  end

  assign isolate_o     = isolate_q;
  assign slv_rst_o     = slv_rst_q;
  assign irq_o         = irq_q;
  assign iso_timeout_o = iso_to_q;
  assign locked_o      = locked_q;
  assign busy_o        = busy_q;
  assign state_o       = state_q;
  assign recov_cnt_o   = cnt_q;

endmodule

// File: tb/tb_slv_guard_recovery_ctrl.sv
// -----------------------------------------------------------------------------
// tb_slv_guard_recovery_ctrl
// Directed and randomized sequences against a duration-level reference model:
// each recovery is predicted from its acknowledge delay as phase lengths
// (isolate, reset, settle), plus the recovery count, sticky flags and the
// state that follows RELEASE.
// -----------------------------------------------------------------------------
module tb_slv_guard_recovery_ctrl;

  localparam int R = 16;
  localparam int S = 8;
  localparam int T = 256;
  localparam int M = 3;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       guard_ena_i;
  logic       rst_req_i;
  logic       isolated_i;
  logic       sw_clear_i;
  logic       isolate_o;
  logic       slv_rst_o;
  logic       irq_o;
  logic       iso_timeout_o;
  logic       locked_o;
  logic       busy_o;
  logic [2:0] state_o;
  logic [7:0] recov_cnt_o;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int model_cnt = 0;
  bit model_to  = 1'b0;

  always #5 clk_i = ~clk_i;

  slv_guard_recovery_ctrl #(
    .RstCycles    (R),
    .SettleCycles (S),
    .IsoTimeout   (T),
    .MaxRecoveries(M)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .guard_ena_i  (guard_ena_i),
    .rst_req_i    (rst_req_i),
    .isolated_i   (isolated_i),
    .sw_clear_i   (sw_clear_i),
    .isolate_o    (isolate_o),
    .slv_rst_o    (slv_rst_o),
    .irq_o        (irq_o),
    .iso_timeout_o(iso_timeout_o),
    .locked_o     (locked_o),
    .busy_o       (busy_o),
    .state_o      (state_o),
    .recov_cnt_o  (recov_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Starts at the first ISOLATE sample and follows one recovery to RELEASE,
  // then one more cycle (two when rst_req_i is held and no lockout follows).
  task automatic observe_seq(input int d, input bit hold_req, input bit drop_ena,
                             input string tag);
    int k, iso_hi, rst_hi, rst_first, to_at, rel_at, iso_len;
    bit acked, to_start;
    iso_hi = 0; rst_hi = 0; rst_first = -1; to_at = -1; rel_at = -1; k = 0;
    to_start = iso_timeout_o;
    if (!hold_req) rst_req_i = 1'b0;
    while (rel_at < 0 && k < 1000) begin
      if (isolate_o === 1'b1) iso_hi++;
      if (slv_rst_o === 1'b1) begin
        rst_hi++;
        if (rst_first < 0) rst_first = k;
      end
      if (iso_timeout_o === 1'b1 && to_at < 0) to_at = k;
      if (isolate_o === 1'b0 && busy_o === 1'b1) rel_at = k;
      else begin
        isolated_i = (k >= d);
        if (drop_ena && k == 2) guard_ena_i = 1'b0;
        step();
        k++;
      end
    end
    isolated_i  = 1'b0;
    guard_ena_i = 1'b1;

    // Reference: ack on any ISOLATE cycle up to the one where the timer hits 0.
    acked     = (d <= T - 1);
    iso_len   = acked ? d + 1 : T;
    model_cnt = (model_cnt < 255) ? model_cnt + 1 : 255;
    if (!acked) model_to = 1'b1;

    check({tag, "_release_at"}, rel_at, iso_len + R + S);
    check({tag, "_isolate_len"}, iso_hi, iso_len + R + S);
    check({tag, "_slv_rst_len"}, rst_hi, R);
    check({tag, "_slv_rst_start"}, rst_first, iso_len);
    check({tag, "_recov_cnt"}, recov_cnt_o, model_cnt);
    check({tag, "_iso_timeout"}, iso_timeout_o, model_to);
    check({tag, "_irq"}, irq_o, 1);
    if (!to_start) check({tag, "_timeout_at"}, to_at, acked ? -1 : T);

    step();
    if (model_cnt >= M) begin
      check({tag, "_locked_state"}, state_o, 5);
      check({tag, "_locked_o"}, locked_o, 1);
    end else begin
      check({tag, "_idle_state"}, state_o, 0);
      check({tag, "_idle_busy"}, busy_o, 0);
      if (hold_req) begin
        step();
        check({tag, "_retrigger"}, state_o, 1);
      end
    end
  endtask

  initial begin
    int  cnt_err;
    bit  found, in_iso;

    rst_i = 1'b1; guard_ena_i = 1'b0; rst_req_i = 1'b0;
    isolated_i = 1'b0; sw_clear_i = 1'b0;
    #12;
    check("rst_state", state_o, 0);
    check("rst_isolate", isolate_o, 0);
    check("rst_slv_rst", slv_rst_o, 0);
    check("rst_irq", irq_o, 0);
    check("rst_iso_timeout", iso_timeout_o, 0);
    check("rst_locked", locked_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_cnt", recov_cnt_o, 0);
    step();
    rst_i = 1'b0;

    // Request while disabled is held off; enabling starts next cycle.
    rst_req_i = 1'b1;
    cnt_err = 0;
    repeat (4) begin
      step();
      if (busy_o !== 1'b0) cnt_err++;
    end
    check("disabled_busy_cycles", cnt_err, 0);
    guard_ena_i = 1'b1;
    step();
    check("enable_isolate", state_o, 1);
    check("enable_irq", irq_o, 1);
    observe_seq(5, 1'b0, 1'b0, "base");

    // Software clear in IDLE drops the interrupt but keeps the count.
    sw_clear_i = 1'b1;
    step();
    sw_clear_i = 1'b0;
    check("clr_idle_irq", irq_o, 0);
    check("clr_idle_cnt", recov_cnt_o, 1);

    // Isolation never acknowledged.
    rst_req_i = 1'b1;
    step();
    check("timeout_trigger", state_o, 1);
    observe_seq(1000, 1'b0, 1'b0, "timeout");

    // Third recovery, with enable dropped mid-sequence, locks out.
    rst_req_i = 1'b1;
    step();
    observe_seq(3, 1'b0, 1'b1, "lock");
    check("locked_isolate", isolate_o, 1);
    check("locked_slv_rst", slv_rst_o, 0);
    check("locked_busy", busy_o, 1);
    rst_req_i = 1'b1;
    cnt_err = 0;
    repeat (10) begin
      step();
      if (state_o !== 3'd5) cnt_err++;
    end
    check("locked_ignores_req", cnt_err, 0);
    rst_req_i  = 1'b0;
    sw_clear_i = 1'b1;
    step();
    sw_clear_i = 1'b0;
    model_cnt = 0; model_to = 1'b0;
    check("unlock_state", state_o, 0);
    check("unlock_cnt", recov_cnt_o, 0);
    check("unlock_irq", irq_o, 0);
    check("unlock_iso_timeout", iso_timeout_o, 0);
    check("unlock_locked", locked_o, 0);

    // Same-cycle trigger and clear: the set wins.
    rst_req_i  = 1'b1;
    sw_clear_i = 1'b1;
    step();
    sw_clear_i = 1'b0;
    check("set_wins_state", state_o, 1);
    check("set_wins_irq", irq_o, 1);
    observe_seq(7, 1'b1, 1'b0, "held_req");
    observe_seq(0, 1'b0, 1'b0, "back_to_back");

    // Asynchronous reset in the middle of RESET.
    rst_req_i = 1'b1;
    step();
    rst_req_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (slv_rst_o === 1'b1) found = 1'b1;
      else begin
        isolated_i = 1'b1;
        step();
      end
    end
    isolated_i = 1'b0;
    check("reach_reset_phase", found, 1);
    repeat (3) step();
    rst_i = 1'b1;
    #1;
    check("async_rst_slv_rst", slv_rst_o, 0);
    check("async_rst_state", state_o, 0);
    check("async_rst_isolate", isolate_o, 0);
    check("async_rst_cnt", recov_cnt_o, 0);
    check("async_rst_irq", irq_o, 0);
    model_cnt = 0; model_to = 1'b0;
    rst_req_i = 1'b1; guard_ena_i = 1'b1;
    #2;
    rst_i = 1'b0;
    step();
    check("first_edge_after_reset", state_o, 1);
    observe_seq(int'($urandom_range(0, 10)), 1'b0, 1'b0, "post_reset");

    // Randomized recoveries: ack delay, held request and enable drop.
    in_iso = 1'b0;
    for (int i = 0; i < 8; i++) begin
      int d;
      bit hold, drop;
      d    = ($urandom_range(0, 7) == 0) ? 300 : int'($urandom_range(0, 40));
      hold = 1'($urandom_range(0, 1));
      drop = 1'($urandom_range(0, 1));
      if (!in_iso) begin
        rst_req_i = 1'b1; guard_ena_i = 1'b1;
        step();
        check("rand_trigger", state_o, 1);
      end
      observe_seq(d, hold, drop, "rand");
      in_iso = hold && (model_cnt < M);
      if (model_cnt >= M) begin
        rst_req_i  = 1'b0;
        sw_clear_i = 1'b1;
        step();
        sw_clear_i = 1'b0;
        model_cnt = 0; model_to = 1'b0;
        check("rand_unlock", state_o, 0);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
